uart_txd_fifo: RTL and testbench

Buffered UART transmitter that accepts bytes from on-chip logic into a 16-deep FIFO. It serialises them onto txd_pin as 8N1 frames at a fixed baud rate. It is the transmit-side counterpart to uart_rxd for any sender that produces bursts faster than the line rate, such as status dumps or multi-byte replies. Bytes are sent back-to-back with no idle gap while the FIFO holds data.

---
 rtl/uart_txd_fifo_if.sv | 24 ++
 rtl/uart_txd_fifo.sv | 129 ++++++++++++
 tb/tb_uart_txd_fifo.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_txd_fifo_if.sv
// Write-side and line-side signals of the buffered UART transmitter.
// The producer uses the master modport; the transmitter uses the slave modport.
interface uart_txd_fifo_if #(
  parameter int unsigned FIFO_AW = 4
) ();
  logic               wr_en;
  logic [7:0]         wr_data;
  logic               full;
  logic               empty;
  logic [FIFO_AW:0]   level;
  logic               overflow;
  logic               tx_busy;
  logic               txd_pin;

  modport master (
    output wr_en, wr_data,
    input  full, empty, level, overflow, tx_busy, txd_pin
  );

  modport slave (
    input  wr_en, wr_data,
    output full, empty, level, overflow, tx_busy, txd_pin
  );
endinterface

// File: rtl/uart_txd_fifo.sv
// Buffered 8N1 UART transmitter: a 2**FIFO_AW-byte FIFO feeding a start/data/stop serialiser.
// Queued bytes leave back-to-back with no idle cycle between frames.
module uart_txd_fifo #(
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter int unsigned BAUD     = 115200,
  parameter int unsigned FIFO_AW  = 4
) (
  input  logic           clk50M,
  input  logic           rst_n,
  uart_txd_fifo_if.slave tx_if
);
  localparam int unsigned BitCycles = CLK_FREQ / BAUD;
  localparam int unsigned Depth     = 2 ** FIFO_AW;
  localparam int unsigned CntW      = (BitCycles > 1) ? $clog2(BitCycles) : 1;
  localparam logic [CntW-1:0]  CntLast  = CntW'(BitCycles - 1);
  localparam logic [FIFO_AW:0] DepthCnt = {1'b1, {FIFO_AW{1'b0}}};

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  logic [7:0]         mem_q [Depth];
  logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]   count_q, count_d;
  logic               full_q, empty_q, overflow_q;

  state_e             state_q;
  logic [CntW-1:0]    cnt_q;
  logic [2:0]         bit_q;
  logic [7:0]         shift_q;
  logic               txd_q, busy_q;

  logic push, pop, tick;

  // full_q is the pre-edge occupancy, so a same-cycle pop never makes room for a write.
  assign push = tx_if.wr_en & ~full_q;
  assign tick = (cnt_q == CntLast);
  assign pop  = ~empty_q & ((state_q == StIdle) | ((state_q == StStop) & tick));

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk50M or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q    <= count_d;
      full_q     <= (count_d == DepthCnt);
      empty_q    <= (count_d == '0);
      overflow_q <= tx_if.wr_en & full_q;
    end
  end

  always_ff @(posedge clk50M) begin
    if (push) mem_q[wr_ptr_q] <= tx_if.wr_data;
  end

  // Line outputs are registered from the current state, trailing the state by one clock.
  always_ff @(posedge clk50M or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle:  txd_q <= 1'b1;
        StStart: txd_q <= 1'b0;
        StData:  txd_q <= shift_q[bit_q];
        StStop:  txd_q <= 1'b1;
      endcase
      busy_q <= (state_q != StIdle);
      cnt_q  <= tick ? '0 : cnt_q + 1'b1;

      unique case (state_q)
        StIdle: begin
          cnt_q <= '0;
          if (pop) begin
            shift_q <= mem_q[rd_ptr_q];
            state_q <= StStart;
          end
        end
        StStart: begin
          if (tick) begin
            state_q <= StData;
            bit_q   <= '0;
          end
        end
        StData: begin
          if (tick) begin
            bit_q <= bit_q + 1'b1;
            if (bit_q == 3'd7) state_q <= StStop;
          end
        end
        StStop: begin
          if (tick) begin
            if (pop) begin
              shift_q <= mem_q[rd_ptr_q];
              state_q <= StStart;
            end else begin
              state_q <= StIdle;
            end
          end
        end
      endcase
    end
  end

  assign tx_if.full     = full_q;
  assign tx_if.empty    = empty_q;
  assign tx_if.level    = count_q;
  assign tx_if.overflow = overflow_q;
  assign tx_if.tx_busy  = busy_q;
  assign tx_if.txd_pin  = txd_q;

endmodule

// File: tb/tb_uart_txd_fifo.sv
// Directed bench for uart_txd_fifo at a reduced bit time (10 clocks per bit, 100 per frame).
// A behavioural 8N1 receiver on txd_pin collects bytes and start-bit cycles.
module tb_uart_txd_fifo;
  localparam int unsigned ClkFreq = 1_000_000;
  localparam int unsigned Baud    = 100_000;
  localparam int unsigned Bc      = 10;
  localparam int unsigned Frame   = 10 * Bc;
  localparam logic [9:0]  StReset = {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0};

  logic        clk50M = 1'b0;
  logic        rst_n  = 1'b0;
  int unsigned cyc    = 0;
  int unsigned checks = 0;
  int unsigned errors = 0;

  uart_txd_fifo_if #(.FIFO_AW(4)) tx_if ();

  uart_txd_fifo #(
    .CLK_FREQ(ClkFreq),
    .BAUD    (Baud),
    .FIFO_AW (4)
  ) dut (
    .clk50M(clk50M),
    .rst_n (rst_n),
    .tx_if (tx_if)
  );

  always #5 clk50M = ~clk50M;
  always @(posedge clk50M) cyc <= cyc + 1;

  int unsigned ovf_cnt = 0;
  always @(negedge clk50M) if (tx_if.overflow === 1'b1) ovf_cnt <= ovf_cnt + 1;

  logic [7:0]  rx_q [$];
  int unsigned rx_t [$];
  int unsigned rx_stop_err = 0;

  initial begin : rx_model
    logic [7:0]  b;
    int unsigned t;
    forever begin
      @(negedge clk50M);
      if (rst_n && tx_if.txd_pin === 1'b0) begin
        t = cyc;
        repeat (Bc / 2) @(negedge clk50M);
        for (int i = 0; i < 8; i++) begin
          repeat (Bc) @(negedge clk50M);
          b[i] = tx_if.txd_pin;
        end
        repeat (Bc) @(negedge clk50M);
        if (tx_if.txd_pin !== 1'b1) rx_stop_err++;
        rx_q.push_back(b);
        rx_t.push_back(t);
      end
    end
  end

  function automatic logic [9:0] status();
    return {tx_if.txd_pin, tx_if.tx_busy, tx_if.full, tx_if.empty, tx_if.overflow, tx_if.level};
  endfunction

  task automatic clk_step();
    @(posedge clk50M);
    #1;
  endtask

  task automatic wait_until(input int unsigned target);
    while (cyc < target) clk_step();
  endtask

  task automatic write_byte(input logic [7:0] d);
    tx_if.wr_en   = 1'b1;
    tx_if.wr_data = d;
    clk_step();
    tx_if.wr_en   = 1'b0;
  endtask

  task automatic test_reset();
    tx_if.wr_en   = 1'b0;
    tx_if.wr_data = 8'h00;
    rst_n         = 1'b0;
    repeat (3) clk_step();
    checks++;
    if (status() !== StReset) begin
      errors++;
      $display("FAIL reset_outputs: got %h want %h", status(), StReset);
    end
    #2 rst_n = 1'b1;
    repeat (3) clk_step();
    checks++;
    if (status() !== StReset) begin
      errors++;
      $display("FAIL reset_release_idle: got %h want %h", status(), StReset);
    end
  endtask

  task automatic test_single_byte();
    int unsigned n, base;
    logic [9:0]  fr;
    base = rx_q.size();
    fr   = {1'b1, 8'h55, 1'b0};
    write_byte(8'h55);
    n = cyc;
    checks++;
    if (status() !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1}) begin
      errors++;
      $display("FAIL single_accept: got %h want %h", status(), {5'b10000, 5'd1});
    end
    clk_step();
    checks++;
    if (status() !== {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0}) begin
      errors++;
      $display("FAIL single_pop: got %h want %h", status(), {5'b10010, 5'd0});
    end
    clk_step();
    checks++;
    if (status() !== {1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0}) begin
      errors++;
      $display("FAIL single_start_edge: got %h want %h", status(), {5'b01010, 5'd0});
    end
    for (int k = 0; k < 10; k++) begin
      wait_until(n + 2 + k * Bc + Bc / 2);
      checks++;
      if (tx_if.txd_pin !== fr[k]) begin
        errors++;
        $display("FAIL single_bit%0d: got %b want %b", k, tx_if.txd_pin, fr[k]);
      end
    end
    wait_until(n + 1 + Frame);
    checks++;
    if (tx_if.tx_busy !== 1'b1) begin
      errors++;
      $display("FAIL single_busy_last: got %b want 1", tx_if.tx_busy);
    end
    clk_step();
    checks++;
    if ({tx_if.tx_busy, tx_if.txd_pin} !== 2'b01) begin
      errors++;
      $display("FAIL single_busy_end: got %b want 01", {tx_if.tx_busy, tx_if.txd_pin});
    end
    wait_until(n + 2 + Frame + Bc);
    checks++;
    if (rx_q.size() != base + 1 || rx_q[base] !== 8'h55) begin
      errors++;
      $display("FAIL single_rx: got %0d bytes last %h want 1 byte 55", rx_q.size() - base,
               rx_q[rx_q.size() - 1]);
    end
  endtask

  task automatic test_back_to_back();
    int unsigned n, base, gaps;
    logic [7:0]  exp_b [3];
    exp_b = '{8'hA5, 8'h00, 8'hFF};
    base  = rx_q.size();
    gaps  = 0;
    write_byte(8'hA5);
    n = cyc;
    write_byte(8'h00);
    checks++;
    if (tx_if.level !== 5'd1) begin
      errors++;
      $display("FAIL b2b_level_mid: got %0d want 1", tx_if.level);
    end
    write_byte(8'hFF);
    checks++;
    if (tx_if.level !== 5'd2) begin
      errors++;
      $display("FAIL b2b_level_peak: got %0d want 2", tx_if.level);
    end
    while (cyc < n + 1 + 3 * Frame) begin
      clk_step();
      if (tx_if.tx_busy !== 1'b1) gaps++;
      if (cyc == n + 200) begin
        checks++;
        if (tx_if.empty !== 1'b0) begin
          errors++;
          $display("FAIL b2b_empty_before_pop3: got %b want 0", tx_if.empty);
        end
      end
      if (cyc == n + 201) begin
        checks++;
        if (tx_if.empty !== 1'b1) begin
          errors++;
          $display("FAIL b2b_empty_after_pop3: got %b want 1", tx_if.empty);
        end
      end
    end
    checks++;
    if (gaps != 0) begin
      errors++;
      $display("FAIL b2b_no_gap: got %0d idle cycles want 0", gaps);
    end
    wait_until(n + 2 + 3 * Frame + Bc);
    checks++;
    if (rx_q.size() != base + 3) begin
      errors++;
      $display("FAIL b2b_rx_count: got %0d want 3", rx_q.size() - base);
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (rx_q[base + i] !== exp_b[i] || rx_t[base + i] != n + 2 + i * Frame) begin
          errors++;
          $display("FAIL b2b_frame%0d: got %h at %0d want %h at %0d", i, rx_q[base + i],
                   rx_t[base + i], exp_b[i], n + 2 + i * Frame);
        end
      end
    end
  endtask

  task automatic test_overflow();
    int unsigned n, base, ob;
    base = rx_q.size();
    ob   = ovf_cnt;
    write_byte(8'h01);
    n = cyc;
    for (int i = 2; i <= 17; i++) write_byte(8'(i));
    checks++;
    if ({tx_if.full, tx_if.level} !== {1'b1, 5'd16}) begin
      errors++;
      $display("FAIL ovf_full: got full=%b level=%0d want full=1 level=16", tx_if.full,
               tx_if.level);
    end
    write_byte(8'h12);
    checks++;
    if ({tx_if.overflow, tx_if.full, tx_if.level} !== {2'b11, 5'd16}) begin
      errors++;
      $display("FAIL ovf_pulse: got %b want 1116", {tx_if.overflow, tx_if.full, tx_if.level});
    end
    clk_step();
    checks++;
    if (tx_if.overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_one_cycle: got %b want 0", tx_if.overflow);
    end
    wait_until(n + 2 + 17 * Frame + Bc);
    checks++;
    if (rx_q.size() != base + 17) begin
      errors++;
      $display("FAIL ovf_rx_count: got %0d want 17", rx_q.size() - base);
    end else begin
      for (int i = 0; i < 17; i++) begin
        checks++;
        if (rx_q[base + i] !== 8'(i + 1)) begin
          errors++;
          $display("FAIL ovf_rx_byte%0d: got %h want %h", i, rx_q[base + i], 8'(i + 1));
        end
      end
    end
    checks++;
    if (ovf_cnt - ob != 1) begin
      errors++;
      $display("FAIL ovf_pulse_count: got %0d want 1", ovf_cnt - ob);
    end
  endtask

  task automatic test_full_pop();
    int unsigned n, base;
    base = rx_q.size();
    write_byte(8'h20);
    n = cyc;
    for (int i = 1; i <= 16; i++) write_byte(8'(8'h20 + i));
    wait_until(n + Frame);
    write_byte(8'hEE);
    checks++;
    if ({tx_if.overflow, tx_if.full, tx_if.level} !== {2'b10, 5'd15}) begin
      errors++;
      $display("FAIL fullpop_drop: got %b want 1015", {tx_if.overflow, tx_if.full, tx_if.level});
    end
    write_byte(8'h31);
    checks++;
    if ({tx_if.overflow, tx_if.full, tx_if.level} !== {2'b01, 5'd16}) begin
      errors++;
      $display("FAIL fullpop_next: got %b want 0116", {tx_if.overflow, tx_if.full, tx_if.level});
    end
    wait_until(n + 2 + 18 * Frame + Bc);
    checks++;
    if (rx_q.size() != base + 18) begin
      errors++;
      $display("FAIL fullpop_rx_count: got %0d want 18", rx_q.size() - base);
    end else begin
      for (int i = 0; i < 18; i++) begin
        checks++;
        if (rx_q[base + i] !== 8'(8'h20 + i)) begin
          errors++;
          $display("FAIL fullpop_rx_byte%0d: got %h want %h", i, rx_q[base + i], 8'(8'h20 + i));
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int unsigned n, viol, base;
    write_byte(8'hC3);
    n = cyc;
    for (int i = 0; i < 5; i++) write_byte(8'(8'h70 + i));
    checks++;
    if (tx_if.level !== 5'd5) begin
      errors++;
      $display("FAIL rstmid_level: got %0d want 5", tx_if.level);
    end
    wait_until(n + 12 + 3 * Bc + Bc / 2);
    checks++;
    if (tx_if.txd_pin !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_bit3: got %b want 0", tx_if.txd_pin);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (status() !== StReset) begin
      errors++;
      $display("FAIL rstmid_async: got %h want %h", status(), StReset);
    end
    repeat (3) clk_step();
    #2 rst_n = 1'b1;
    viol = 0;
    repeat (3 * Frame) begin
      clk_step();
      if (tx_if.txd_pin !== 1'b1 || tx_if.tx_busy !== 1'b0 || tx_if.empty !== 1'b1) viol++;
    end
    checks++;
    if (viol != 0) begin
      errors++;
      $display("FAIL rstmid_quiet: got %0d active cycles want 0", viol);
    end
    base = rx_q.size();
    write_byte(8'h5A);
    n = cyc;
    wait_until(n + 2 + Frame + Bc);
    checks++;
    if (rx_q.size() != base + 1 || rx_q[rx_q.size() - 1] !== 8'h5A) begin
      errors++;
      $display("FAIL rstmid_recover: got %0d bytes last %h want 1 byte 5a", rx_q.size() - base,
               rx_q[rx_q.size() - 1]);
    end
  endtask

  task automatic test_loopback();
    int unsigned n, base, ob, drops, sz;
    logic [7:0]  d;
    logic [7:0]  exp_q [$];
    base  = rx_q.size();
    ob    = ovf_cnt;
    drops = 0;
    n     = 0;
    // Each burst starts idle and empty: first byte pops at once, 16 fill the FIFO, rest drop.
    for (int b = 0; b < 3; b++) begin
      sz = (b == 2) ? 24 : 20;
      for (int i = 0; i < int'(sz); i++) begin
        d = 8'($urandom);
        write_byte(d);
        if (i == 0) n = cyc;
        if (i < 17) exp_q.push_back(d);
        else drops++;
      end
      wait_until(n + 2 + 17 * Frame + Bc);
    end
    checks++;
    if (rx_q.size() - base != exp_q.size()) begin
      errors++;
      $display("FAIL loop_rx_count: got %0d want %0d", rx_q.size() - base, exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (rx_q[base + i] !== exp_q[i]) begin
          errors++;
          $display("FAIL loop_byte%0d: got %h want %h", i, rx_q[base + i], exp_q[i]);
        end
      end
    end
    checks++;
    if (ovf_cnt - ob != drops) begin
      errors++;
      $display("FAIL loop_ovf_count: got %0d want %0d", ovf_cnt - ob, drops);
    end
    checks++;
    if (rx_q.size() - base != 64 - (ovf_cnt - ob)) begin
      errors++;
      $display("FAIL loop_rx_vs_ovf: got %0d want %0d", rx_q.size() - base, 64 - (ovf_cnt - ob));
    end
    checks++;
    if (rx_stop_err != 0) begin
      errors++;
      $display("FAIL loop_stop_bits: got %0d bad stop bits want 0", rx_stop_err);
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_overflow();
    test_full_pop();
    test_reset_mid();
    test_loopback();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
